wb_master_arbiter: RTL
======================

Name: wb_master_arbiter

Overview:
- Shares the single Wishbone master port of the SoC interconnect between N_MASTERS requesters (master 0 = bootloader, master 1 = CPU data, others spare).
- Grants one master at a time and holds the grant for the full cyc_o assertion, so multi-step sequences stay atomic (e.g. an address write followed by a data command to the ELUKS block).
- Round-robin or fixed priority, selected at run time.
- Optional watchdog aborts a stalled transfer.

Parameters:
- WB_DATA, 32, data/address width; sel width is WB_DATA>>3.
- N_MASTERS, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 1024, watchdog limit in wb_clk cycles (used only with the macro).

Ports:
- wb_clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- prio_mode_i  in  1  1 = fixed priority (lowest index wins), 0 = round-robin.
- m_cyc_i  in  N_MASTERS  per-master cyc.
- m_stb_i  in  N_MASTERS  per-master stb.
- m_we_i  in  N_MASTERS  per-master we.
- m_sel_i  in  N_MASTERS*(WB_DATA>>3)  per-master sel, packed, master 0 in LSBs.
- m_adr_i  in  N_MASTERS*WB_DATA  per-master address, packed.
- m_dat_i  in  N_MASTERS*WB_DATA  per-master write data, packed.
- m_cti_i  in  N_MASTERS*3  per-master cti.
- m_bte_i  in  N_MASTERS*2  per-master bte.
- m_ack_o  out  N_MASTERS  ack, routed to the granted master only.
- m_err_o  out  N_MASTERS  err, routed to the granted master only.
- m_rty_o  out  N_MASTERS  rty, routed to the granted master only.
- m_dat_o  out  WB_DATA  read data, broadcast to all masters.
- s_cyc_o  out  1  slave-side cyc.
- s_stb_o  out  1  slave-side stb.
- s_we_o  out  1  slave-side we.
- s_sel_o  out  WB_DATA>>3  slave-side sel.
- s_adr_o  out  WB_DATA  slave-side address.
- s_dat_o  out  WB_DATA  slave-side write data.
- s_cti_o  out  3  slave-side cti.
- s_bte_o  out  2  slave-side bte.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_rty_i  in  1  slave rty.
- s_dat_i  in  WB_DATA  slave read data.
- grant_o  out  N_MASTERS  one-hot registered grant.
- busy_o  out  1  high in every state except IDLE.
- timeout_o  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, grant_o = 0, last-granted pointer = N_MASTERS-1, watchdog counter = 0.
  - All s_* outputs 0, all m_ack/err/rty 0, busy_o = 0, timeout_o = 0.
  - Reset mid-transfer drops s_cyc_o immediately; no completion is reported to the master.
- m_dat_o = s_dat_i, always combinational.
- State IDLE:
  - Slave outputs are 0.
  - If any m_cyc_i is high, select a winner:
    - prio_mode_i = 1: lowest set index wins.
    - prio_mode_i = 0: first set index after the last-granted pointer, wrapping modulo N_MASTERS.
  - Register grant_o = onehot(winner) and go to BUSY.
  - Arbitration latency: exactly 1 cycle from m_cyc_i rising to s_cyc_o rising.
  - prio_mode_i is sampled only in IDLE.
- State BUSY:
  - Slave outputs are driven combinationally from the granted master's signals.
  - s_ack/s_err/s_rty are forwarded only to the granted master; non-granted masters see 0 and stall.
  - Granted m_cyc_i low: set last-granted pointer = granted index, clear grant_o, go to IDLE. No new grant is issued in the same cycle, so there is a 1 idle cycle between owners.
  - Requests from other masters during BUSY are ignored until IDLE.
  - s_cyc_o follows the granted m_cyc_i, so a master holding cyc across several stb strobes (with stb gaps) keeps ownership.
- State ABORT (macro only):
  - One cycle. s_cyc_o = s_stb_o = 0; m_err_o of the granted master = 1; timeout_o = 1.
  - Then go to DRAIN.
- State DRAIN (macro only):
  - Slave outputs are 0. Wait for the granted m_cyc_i to go low, then update the pointer and go to IDLE as in BUSY.
- Simultaneous ack and cyc drop in the same cycle: the ack is forwarded, then release.
- Slave ack arriving in IDLE or DRAIN is discarded.

Optional Feature:
- Macro: WB_MASTER_ARBITER_TIMEOUT_EN.
- With the macro:
  - A 32-bit watchdog counter clears on entry to BUSY and on any s_ack_i, s_err_i or s_rty_i.
  - It increments each BUSY cycle with s_stb_o high.
  - When the count equals TIMEOUT_CYCLES-1 and no response is present, go to ABORT.
- Without the macro:
  - No counter, ABORT and DRAIN do not exist, timeout_o is tied to 0.
  - A stalled slave holds the grant indefinitely.

Test Plan:
- Reset: rst_n low with m_cyc_i = 2'b11 -> grant_o = 0, s_cyc_o = 0, busy_o = 0. Release rst_n -> s_cyc_o = 1 one cycle after the next clock.
- Fixed priority: prio_mode_i = 1, both masters request repeatedly, slave acks after 2 cycles -> master 0 is granted on every arbitration; master 1 gets no ack until master 0 drops cyc.
- Round-robin:
  - prio_mode_i = 0, N_MASTERS = 3, all masters hold cyc for one transfer each and re-request -> grant sequence 0,1,2,0.
  - Exactly 1 idle cycle (busy_o = 0) between grants.
- Atomic sequence: master 0 writes 32'h92000003 then 32'h92000006 under a single cyc while master 1 requests -> master 1 is not granted until master 0 drops cyc; s_adr_o/s_dat_o match master 0 throughout.
- Watchdog (macro on, TIMEOUT_CYCLES = 16): slave never acks ->
  - m_err_o[granted] and timeout_o pulse exactly 16 cycles after s_stb_o rose.
  - s_cyc_o = 0 from then on; grant released after the master drops cyc.
- Response routing: slave asserts s_err_i to granted master 1 -> m_err_o = 2'b10; m_ack_o = 0; m_dat_o equals s_dat_i.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// Wishbone master-port arbiter: N_MASTERS requesters share one slave port; a grant is held for the whole cyc.
// Define WB_MASTER_ARBITER_TIMEOUT_EN to add the stalled-slave watchdog (ABORT/DRAIN states, timeout_o).
module wb_master_arbiter #(
  parameter int WB_DATA        = 32,
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                wb_clk,
  input  logic                                rst_n,
  input  logic                                prio_mode_i,
  input  logic [N_MASTERS-1:0]                m_cyc_i,
  input  logic [N_MASTERS-1:0]                m_stb_i,
  input  logic [N_MASTERS-1:0]                m_we_i,
  input  logic [N_MASTERS*(WB_DATA>>3)-1:0]   m_sel_i,
  input  logic [N_MASTERS*WB_DATA-1:0]        m_adr_i,
  input  logic [N_MASTERS*WB_DATA-1:0]        m_dat_i,
  input  logic [N_MASTERS*3-1:0]              m_cti_i,
  input  logic [N_MASTERS*2-1:0]              m_bte_i,
  output logic [N_MASTERS-1:0]                m_ack_o,
  output logic [N_MASTERS-1:0]                m_err_o,
  output logic [N_MASTERS-1:0]                m_rty_o,
  output logic [WB_DATA-1:0]                  m_dat_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [(WB_DATA>>3)-1:0]             s_sel_o,
  output logic [WB_DATA-1:0]                  s_adr_o,
  output logic [WB_DATA-1:0]                  s_dat_o,
  output logic [2:0]                          s_cti_o,
  output logic [1:0]                          s_bte_o,
  input  logic                                s_ack_i,
  input  logic                                s_err_i,
  input  logic                                s_rty_i,
  input  logic [WB_DATA-1:0]                  s_dat_i,
  output logic [N_MASTERS-1:0]                grant_o,
  output logic                                busy_o,
  output logic                                timeout_o
);

  localparam int SEL_W = WB_DATA >> 3;
  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     win_idx;
  logic                 g_cyc, g_stb;

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (grant_q[i]) gnt_idx = IDX_W'(i);
  end

  // Scan from the far end so the last hit is the lowest index (fixed) or nearest after the pointer (round-robin).
  always_comb begin
    int cand;
    win_idx = '0;
    cand    = 0;
    if (prio_mode_i) begin
      for (int i = N_MASTERS - 1; i >= 0; i--)
        if (m_cyc_i[i]) win_idx = IDX_W'(i);
    end else begin
      for (int k = N_MASTERS; k >= 1; k--) begin
        cand = int'(last_q) + k;
        if (cand >= N_MASTERS) cand = cand - N_MASTERS;
        if (m_cyc_i[cand]) win_idx = IDX_W'(cand);
      end
    end
  end

  assign g_cyc = m_cyc_i[gnt_idx];
  assign g_stb = m_stb_i[gnt_idx];

`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        wd_expire;
  logic        any_resp;

  assign any_resp  = s_ack_i | s_err_i | s_rty_i;
  assign wd_expire = g_stb && !any_resp && (wd_q == 32'(TIMEOUT_CYCLES - 1));

  // Holding the count at zero throughout IDLE gives the clear-on-entry to BUSY.
  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE)
      wd_d = '0;
    else if (state_q == BUSY) begin
      if (any_resp)   wd_d = '0;
      else if (g_stb) wd_d = wd_q + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    timeout_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          grant_d = N_MASTERS'(1) << win_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_we_o  = m_we_i[gnt_idx];
        s_sel_o = m_sel_i[gnt_idx*SEL_W +: SEL_W];
        s_adr_o = m_adr_i[gnt_idx*WB_DATA +: WB_DATA];
        s_dat_o = m_dat_i[gnt_idx*WB_DATA +: WB_DATA];
        s_cti_o = m_cti_i[gnt_idx*3 +: 3];
        s_bte_o = m_bte_i[gnt_idx*2 +: 2];
        m_ack_o = grant_q & {N_MASTERS{s_ack_i}};
        m_err_o = grant_q & {N_MASTERS{s_err_i}};
        m_rty_o = grant_q & {N_MASTERS{s_rty_i}};
        if (!g_cyc) begin
          grant_d = '0;
          last_d  = gnt_idx;
          state_d = IDLE;
        end
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
        else if (wd_expire) begin
          state_d = ABORT;
        end
`endif
      end
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
      ABORT: begin
        m_err_o   = grant_q;
        timeout_o = 1'b1;
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (!g_cyc) begin
          grant_d = '0;
          last_d  = gnt_idx;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef WB_MASTER_ARBITER_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

endmodule
